// File: rtl/s2qed_lockstep_feeder.sv
// s2qed_lockstep_feeder: serves both cores' memory requests together so
// that they always see the same instruction/data stream in the same cycle.
// It flags requests that differ between the cores (mismatch) and flags
// one core waiting too long for the other (skew_err).
module s2qed_lockstep_feeder #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cpu0_req_valid,
  output logic              cpu0_req_ready,
  input  logic [ADDR_W-1:0] cpu0_req_addr,
  input  logic              cpu0_req_instr,
  input  logic              cpu0_req_we,
  input  logic [DATA_W-1:0] cpu0_req_wdata,
  output logic              cpu0_rsp_valid,
  output logic [DATA_W-1:0] cpu0_rsp_rdata,
  input  logic              cpu1_req_valid,
  output logic              cpu1_req_ready,
  input  logic [ADDR_W-1:0] cpu1_req_addr,
  input  logic              cpu1_req_instr,
  input  logic              cpu1_req_we,
  input  logic [DATA_W-1:0] cpu1_req_wdata,
  output logic              cpu1_rsp_valid,
  output logic [DATA_W-1:0] cpu1_rsp_rdata,
  input  logic [DATA_W-1:0] src_inst,
  input  logic              src_inst_valid,
  output logic              src_inst_ready,
  input  logic [DATA_W-1:0] src_data,
  output logic [CNT_W-1:0]  inst_count,
  output logic              mismatch,
  output logic              skew_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT0 = 3'd1,  // core1 pending, core0 not yet
    S_WAIT1 = 3'd2,  // core0 pending, core1 not yet
    S_FETCH = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  // TIMEOUT is limited to 1..255, so 8 bits hold the saturating wait count.
  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t              state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                fetch_q, fetch_d;
  logic [CNT_W-1:0]    inst_count_q, inst_count_d;
  logic                mismatch_q, mismatch_d;
  logic                skew_q, skew_d;

  logic                req_ready;
  logic                both_valid;
  logic                req_differs;
  logic [7:0]          wait_cnt_inc;

  assign both_valid = cpu0_req_valid & cpu1_req_valid;

  // Field comparison; we and wdata only matter where cpu0 says they are used.
  assign req_differs = (cpu0_req_addr != cpu1_req_addr)
                     | (cpu0_req_instr != cpu1_req_instr)
                     | (!cpu0_req_instr && (cpu0_req_we != cpu1_req_we))
                     | (!cpu0_req_instr && cpu0_req_we &&
                        (cpu0_req_wdata != cpu1_req_wdata));

  // Saturating increment so a long skew keeps skew_err set without wrapping.
  assign wait_cnt_inc = (wait_cnt_q == TIMEOUT_C) ? wait_cnt_q : wait_cnt_q + 8'd1;

  // Next-state and output decode for the lockstep handshake.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    data_d         = data_q;
    fetch_d        = fetch_q;
    inst_count_d   = inst_count_q;
    mismatch_d     = mismatch_q;
    skew_d         = skew_q;
    req_ready      = 1'b0;
    src_inst_ready = 1'b0;
    cpu0_rsp_valid = 1'b0;
    cpu1_rsp_valid = 1'b0;
    case (state_q)
      S_IDLE, S_WAIT0, S_WAIT1: begin
        if (both_valid) begin
          // Accept both cores together; cpu0's fields define the transaction.
          req_ready  = rstn;
          wait_cnt_d = 8'd0;
          fetch_d    = cpu0_req_instr;
          if (req_differs) mismatch_d = 1'b1;
          if (cpu0_req_instr) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_RESP;
            data_d  = cpu0_req_we ? '0 : src_data;
          end
        end else if ((state_q == S_WAIT1 && !cpu0_req_valid) ||
                     (state_q == S_WAIT0 && !cpu1_req_valid)) begin
          // The waiting core withdrew its request: start over.
          state_d    = S_IDLE;
          wait_cnt_d = 8'd0;
        end else if (cpu0_req_valid || cpu1_req_valid) begin
          state_d    = cpu0_req_valid ? S_WAIT1 : S_WAIT0;
          wait_cnt_d = wait_cnt_inc;
          if (wait_cnt_inc == TIMEOUT_C) skew_d = 1'b1;
        end
      end
      S_FETCH: begin
        src_inst_ready = 1'b1;
        if (src_inst_valid) begin
          data_d  = src_inst;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        cpu0_rsp_valid = 1'b1;
        cpu1_rsp_valid = 1'b1;
        if (fetch_q) inst_count_d = inst_count_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 8'd0;
      data_q       <= '0;
      fetch_q      <= 1'b0;
      inst_count_q <= '0;
      mismatch_q   <= 1'b0;
      skew_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      data_q       <= data_d;
      fetch_q      <= fetch_d;
      inst_count_q <= inst_count_d;
      mismatch_q   <= mismatch_d;
      skew_q       <= skew_d;
    end
  end

  assign cpu0_req_ready = req_ready;
  assign cpu1_req_ready = req_ready;
  assign cpu0_rsp_rdata = data_q;
  assign cpu1_rsp_rdata = data_q;
  assign inst_count     = inst_count_q;
  assign mismatch       = mismatch_q;
  assign skew_err       = skew_q;

endmodule

// File: tb/tb_s2qed_lockstep_feeder.sv
// Testbench for s2qed_lockstep_feeder: a stimulus process issues paired core
// requests and pushes expected responses into a scoreboard queue; a monitor
// pops and compares whenever the DUT strobes rsp_valid.
module tb_s2qed_lockstep_feeder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu0_req_valid = 0, cpu1_req_valid = 0;
  logic        cpu0_req_ready, cpu1_req_ready;
  logic [31:0] cpu0_req_addr = 0, cpu1_req_addr = 0;
  logic        cpu0_req_instr = 0, cpu1_req_instr = 0;
  logic        cpu0_req_we = 0, cpu1_req_we = 0;
  logic [31:0] cpu0_req_wdata = 0, cpu1_req_wdata = 0;
  logic        cpu0_rsp_valid, cpu1_rsp_valid;
  logic [31:0] cpu0_rsp_rdata, cpu1_rsp_rdata;
  logic [31:0] src_inst = 0;
  logic        src_inst_valid = 0;
  logic        src_inst_ready;
  logic [31:0] src_data = 0;
  logic [15:0] inst_count;
  logic        mismatch, skew_err;

  s2qed_lockstep_feeder dut (
    .clk(clk), .rstn(rstn),
    .cpu0_req_valid(cpu0_req_valid), .cpu0_req_ready(cpu0_req_ready),
    .cpu0_req_addr(cpu0_req_addr), .cpu0_req_instr(cpu0_req_instr),
    .cpu0_req_we(cpu0_req_we), .cpu0_req_wdata(cpu0_req_wdata),
    .cpu0_rsp_valid(cpu0_rsp_valid), .cpu0_rsp_rdata(cpu0_rsp_rdata),
    .cpu1_req_valid(cpu1_req_valid), .cpu1_req_ready(cpu1_req_ready),
    .cpu1_req_addr(cpu1_req_addr), .cpu1_req_instr(cpu1_req_instr),
    .cpu1_req_we(cpu1_req_we), .cpu1_req_wdata(cpu1_req_wdata),
    .cpu1_rsp_valid(cpu1_rsp_valid), .cpu1_rsp_rdata(cpu1_rsp_rdata),
    .src_inst(src_inst), .src_inst_valid(src_inst_valid),
    .src_inst_ready(src_inst_ready), .src_data(src_data),
    .inst_count(inst_count), .mismatch(mismatch), .skew_err(skew_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] m_count = 0;
  bit          m_mis = 0;
  bit          m_skew = 0;

  // Monitor: compare each response strobe with the oldest expectation.
  always @(negedge clk) begin
    if (rstn) begin
      if (cpu0_rsp_valid || cpu1_rsp_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected: cyc=%0d rsp_valid=%b%b rdata=%h, required no response",
                   cyc, cpu0_rsp_valid, cpu1_rsp_valid, cpu0_rsp_rdata);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (!(cpu0_rsp_valid && cpu1_rsp_valid) || cpu0_rsp_rdata !== e.data ||
              cpu1_rsp_rdata !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL rsp: valid=%b%b rdata0=%h rdata1=%h cyc=%0d, required valid=11 rdata=%h cyc=%0d",
                     cpu0_rsp_valid, cpu1_rsp_valid, cpu0_rsp_rdata, cpu1_rsp_rdata,
                     cyc, e.data, e.cyc);
          end else begin
            $display("rsp ok: cyc=%0d rdata=%h", cyc, e.data);
          end
        end
      end
      if (cpu0_req_ready || cpu1_req_ready) begin
        checks++;
        if (cpu0_req_ready !== cpu1_req_ready) begin
          errors++;
          $display("FAIL ready_pair: ready0=%b ready1=%b, required equal",
                   cpu0_req_ready, cpu1_req_ready);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_status();
    chk("inst_count", 32'(inst_count), 32'(m_count));
    chk("mismatch", 32'(mismatch), 32'(m_mis));
    chk("skew_err", 32'(skew_err), 32'(m_skew));
  endtask

  // One paired transaction. lag = cycles the later core trails the leader,
  // k = cycles src_inst_valid is held low after a fetch is accepted.
  task automatic do_txn(input logic i0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
                        input logic i1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                        input int lag, input bit lead1, input logic [31:0] sdata,
                        input logic [31:0] sinst, input int k);
    logic [31:0] exp_d;
    bit          differs;
    int          n;
    int          acc;
    exp_d   = i0 ? sinst : (w0 ? 32'h0 : sdata);
    differs = (a0 != a1) || (i0 != i1) || (!i0 && w0 != w1) || (!i0 && w0 && d0 != d1);

    @(posedge clk); #1;
    cpu0_req_addr = a0; cpu0_req_instr = i0; cpu0_req_we = w0; cpu0_req_wdata = d0;
    cpu1_req_addr = a1; cpu1_req_instr = i1; cpu1_req_we = w1; cpu1_req_wdata = d1;
    src_data = sdata;
    src_inst = sinst;
    src_inst_valid = (i0 && k == 0);
    if (lead1) cpu1_req_valid = 1'b1; else cpu0_req_valid = 1'b1;
    for (int j = 0; j < lag; j++) begin
      #1;
      chk("ready_while_single", 32'(cpu0_req_ready | cpu1_req_ready), 32'h0);
      @(posedge clk); #1;
    end
    cpu0_req_valid = 1'b1;
    cpu1_req_valid = 1'b1;
    #1;
    n = 0;
    while (!cpu0_req_ready && n < 50) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    if (!cpu0_req_ready) begin
      errors++;
      $display("FAIL accept_timeout: ready0=%b after %0d cycles, required 1", cpu0_req_ready, n);
      cpu0_req_valid = 0; cpu1_req_valid = 0; src_inst_valid = 0;
      return;
    end
    if (lag >= 15) m_skew = 1;
    if (differs) m_mis = 1;
    acc = cyc + 1;
    sb_q.push_back('{data: exp_d, cyc: (i0 ? acc + 1 + k : acc)});
    $display("txn: instr=%b we=%b addr=%h lag=%0d stall=%0d accept_cyc=%0d exp=%h",
             i0, w0, a0, lag, k, acc, exp_d);
    @(posedge clk); #1;
    cpu0_req_valid = 0;
    cpu1_req_valid = 0;
    if (i0) begin
      for (int j = 0; j < k; j++) begin
        chk("src_ready_stall", 32'(src_inst_ready), 32'h1);
        @(posedge clk); #1;
      end
      src_inst_valid = 1'b1;
      if (k > 0) begin
        @(posedge clk); #1;
      end else begin
        @(posedge clk); #1;
      end
      src_inst_valid = 1'b0;
      m_count = m_count + 16'd1;
    end
    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL rsp_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
    chk_status();
  endtask

  task automatic same_txn(input logic i, input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int lag, input bit lead1, input int k);
    do_txn(i, w, a, d, i, w, a, d, lag, lead1, $urandom, $urandom, k);
  endtask

  task automatic rand_txn(input bit inject);
    logic        i, w, i1, w1;
    logic [31:0] a, d, a1, d1;
    int          lag;
    i = 1'($urandom); w = 1'($urandom);
    a = $urandom & 32'hFFFF_FFFC; d = $urandom;
    i1 = i; w1 = w; a1 = a; d1 = d;
    if (inject && ($urandom % 4 == 0)) begin
      case ($urandom % 4)
        0: a1 = a ^ 32'h4;
        1: i1 = ~i;
        2: w1 = ~w;
        default: d1 = ~d;
      endcase
    end
    lag = ($urandom % 8 == 0) ? 16 : int'($urandom % 4);
    do_txn(i, w, a, d, i1, w1, a1, d1, lag, 1'($urandom), $urandom, $urandom, int'($urandom % 4));
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    m_count = 0; m_mis = 0; m_skew = 0;
  endtask

  initial begin
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    chk("reset_rsp_valid", 32'({cpu0_rsp_valid, cpu1_rsp_valid}), 32'h0);
    chk("reset_rdata", cpu0_rsp_rdata, 32'h0);
    chk("reset_src_ready", 32'(src_inst_ready), 32'h0);
    chk_status();

    // Directed: fetch at 0x0, instruction already available.
    do_txn(1, 0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0050_0093, 0);
    // Directed: load at 0x100.
    do_txn(0, 0, 32'h100, 0, 0, 0, 32'h100, 0, 0, 0, 32'hDEAD_BEEF, 0, 0);
    // Directed: cores differ only in wdata with we=0 -> no mismatch.
    do_txn(0, 0, 32'h200, 32'h1, 0, 0, 32'h200, 32'h2, 0, 0, 32'h1234_5678, 0, 0);
    // Directed: fetch with source stalled 6 cycles.
    do_txn(1, 0, 32'h8, 0, 1, 0, 32'h8, 0, 0, 0, 0, 32'hCAFE_F00D, 6);

    // Random matched traffic with small skew.
    for (int t = 0; t < 20; t++) begin
      same_txn(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
               int'($urandom % 4), 1'($urandom), int'($urandom % 4));
    end

    // Skew: 5 cycles is tolerated, 20 cycles trips skew_err but still serves.
    same_txn(1, 0, 32'h40, 0, 5, 0, 0);
    same_txn(1, 0, 32'h44, 0, 20, 0, 0);

    // Store mismatch, then stays sticky across matched traffic.
    do_txn(0, 1, 32'h300, 32'h1, 0, 1, 32'h300, 32'h2, 0, 0, 0, 0, 0);
    for (int t = 0; t < 10; t++) begin
      same_txn(1'($urandom), 1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom,
               0, 0, int'($urandom % 3));
    end

    // Reset during FETCH aborts the fetch with no response.
    @(posedge clk); #1;
    cpu0_req_addr = 32'h80; cpu1_req_addr = 32'h80;
    cpu0_req_instr = 1; cpu1_req_instr = 1;
    cpu0_req_we = 0; cpu1_req_we = 0;
    src_inst_valid = 0;
    cpu0_req_valid = 1; cpu1_req_valid = 1;
    @(posedge clk); #1;
    cpu0_req_valid = 0; cpu1_req_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("pre_reset_src_ready", 32'(src_inst_ready), 32'h1);
    rstn = 0;
    @(posedge clk); #1;
    rstn = 1;
    m_count = 0; m_mis = 0; m_skew = 0;
    $display("reset applied during fetch at cyc=%0d", cyc);
    chk("abort_rsp_valid", 32'({cpu0_rsp_valid, cpu1_rsp_valid}), 32'h0);
    chk("abort_src_ready", 32'(src_inst_ready), 32'h0);
    chk("abort_req_ready", 32'({cpu0_req_ready, cpu1_req_ready}), 32'h0);
    chk("abort_rdata", cpu1_rsp_rdata, 32'h0);
    chk_status();
    src_inst = 32'h1111_2222;
    src_inst_valid = 1;
    repeat (3) @(posedge clk);
    #1;
    src_inst_valid = 0;
    chk_status();

    // Random traffic including divergent requests.
    for (int t = 0; t < 20; t++) rand_txn(1);

    apply_reset();
    same_txn(1, 0, 32'h0, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/s2qed_lockstep_feeder.md
Name: s2qed_lockstep_feeder

Overview:
Memory-side responder for the S2QED dual-core harness. It sits between the two mriscvcore instances' memory request ports and a free instruction/data source. It serves every fetch or load to both cores in lockstep, with identical data in the same cycle, so the two cores always execute the same instruction stream. It also flags request divergence and excessive inter-core skew, giving the register-equality checker a consistent environment.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, instruction/data width
TIMEOUT, 15, max cycles one core may wait for the other before skew_err sets (1..255)
CNT_W, 16, width of inst_count

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cpuN_req_valid  in  1  core N request pending, held until req_ready (N = 0,1, one port set per core)
cpuN_req_ready  out  1  request accepted this cycle
cpuN_req_addr  in  ADDR_W  request address
cpuN_req_instr  in  1  1 = instruction fetch, 0 = data access
cpuN_req_we  in  1  data write (ignored when req_instr = 1)
cpuN_req_wdata  in  DATA_W  write data
cpuN_rsp_valid  out  1  one-cycle response strobe
cpuN_rsp_rdata  out  DATA_W  returned instruction/data
src_inst  in  DATA_W  next instruction from the free source
src_inst_valid  in  1  src_inst available
src_inst_ready  out  1  feeder consumes src_inst when both are high
src_data  in  DATA_W  value returned for data loads (sampled at accept)
inst_count  out  CNT_W  lockstep fetches completed
mismatch  out  1  sticky: accepted requests differed
skew_err  out  1  sticky: wait exceeded TIMEOUT

Behaviour:
- Reset (rstn = 0 at posedge):
  - state = IDLE; all outputs 0; wait counter 0; latched data 0.
  - Reset mid-transaction aborts it. Nothing is consumed from src and no response is issued.
- States: IDLE, WAIT0 (core1 pending, core0 not), WAIT1 (core0 pending, core1 not), FETCH, RESP.
- IDLE / WAIT0 / WAIT1:
  - Both req_valid = 1: cpu0_req_ready = cpu1_req_ready = 1 combinationally in that same cycle (always both together, never one alone).
  - At the accepting edge the feeder latches cpu0's fields, then moves to:
    - FETCH if req_instr = 1;
    - RESP otherwise. A load latches src_data; a store latches 0.
  - Only one valid: go to or stay in WAIT1/WAIT0, increment the wait counter. When the counter reaches TIMEOUT, skew_err <= 1; the counter saturates and the feeder keeps waiting.
  - Valid drops in a WAIT state (protocol violation by the core): return to IDLE, counter 0.
  - On accept the counter clears.
- Mismatch at accept: any of the following sets mismatch <= 1 (sticky until reset):
  - addr differs;
  - req_instr differs;
  - req_we differs (data access only);
  - wdata differs (store only).
  - The transaction is still served using cpu0's fields.
- FETCH:
  - src_inst_ready = 1.
  - On src_inst_valid = 1, latch src_inst and go to RESP.
  - Stalls indefinitely otherwise; the timeout does not apply.
- RESP:
  - cpu0_rsp_valid = cpu1_rsp_valid = 1 for exactly one cycle, with identical rsp_rdata.
  - If the transaction was a fetch, inst_count += 1 (wraps from all-ones to 0).
  - Next state IDLE. req_ready is 0 in FETCH and RESP.
- Latency from the accepting cycle T:
  - data access: rsp at T+1;
  - fetch with src_inst_valid already high: FETCH at T+1, rsp at T+2.
- rsp_rdata holds its last value outside RESP (don't-care for checkers).

Test Plan:
- Both cores issue fetch at addr 0x0 in cycle 5, src_inst_valid = 1, src_inst = 0x00500093 -> ready both in cycle 5, rsp_valid both in cycle 7, rdata = 0x00500093 both, inst_count = 1.
- cpu0 fetch at cycle 3, cpu1 at cycle 8 -> state WAIT1 cycles 4-8, ready both in cycle 8 only, skew_err stays 0; repeat with cpu1 delayed 20 cycles -> skew_err = 1 after 15 wait cycles, transaction still completes.
- Both load addr 0x100, src_data = 0xDEADBEEF -> rsp in next cycle with 0xDEADBEEF to both, inst_count unchanged.
- Stores with wdata 0x1 vs 0x2 -> mismatch = 1 and stays 1 through 10 further matched transactions; no change if the cores differ only in wdata with we = 0.
- Fetch accepted, src_inst_valid low for 6 cycles then high -> src_inst_ready high throughout, exactly one inst consumed, rsp one cycle after valid.
- rstn = 0 during FETCH -> next cycle all outputs 0, state IDLE, inst_count 0, no rsp_valid pulse.
